// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a valid/ready channel,
// buffers in-order responses in a 2-entry queue and hands them to decode.
module if_fetch #(
    parameter int          XLEN       = 32,
    parameter int          ADDR_WIDTH = XLEN,
    parameter int          DATA_WIDTH = XLEN,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  stall_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_pc;
    logic [1:0]      r_outstanding;
    logic [1:0]      r_drop_cnt;
    logic [1:0]      r_q_count;
    logic            r_q_head;
    logic [DW-1:0]   r_q_instr [2];
    logic [AW-1:0]   r_q_pc    [2];
    logic [AW-1:0]   r_if_pc   [2];
    logic            r_if_rd;
    logic            r_if_wr;

    logic [2:0]      w_sum;
    logic            w_accept;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_q_tail;
    logic [1:0]      w_out_nxt;
    logic [1:0]      w_drop_reload;
    logic [1:0]      w_drop_nxt;
    logic [AW-1:0]   w_redir_pc;

    // Credit: in-flight requests plus buffered entries never exceed the queue depth.
    assign w_sum            = {1'b0, r_outstanding} + {1'b0, r_q_count};
    assign imem_req_valid_o = (r_state == S_RUN) && !redirect_i && (w_sum < 3'd2);
    assign imem_addr_o      = r_pc;
    assign w_accept         = imem_req_valid_o && imem_req_ready_i;

    assign w_drop   = redirect_i || (r_drop_cnt != 2'd0);
    assign w_push   = imem_rsp_valid_i && !w_drop;
    assign w_pop    = instr_valid_o && !stall_i && !redirect_i;
    assign w_q_tail = r_q_head ^ r_q_count[0];

    assign w_out_nxt     = r_outstanding + {1'b0, w_accept} - {1'b0, imem_rsp_valid_i};
    // No accept can happen in a redirect cycle, so only the returning response is discounted.
    assign w_drop_reload = r_outstanding - {1'b0, imem_rsp_valid_i};
    assign w_drop_nxt    = redirect_i ? w_drop_reload :
                           (imem_rsp_valid_i && r_drop_cnt != 2'd0) ? r_drop_cnt - 2'd1 :
                           r_drop_cnt;
    assign w_redir_pc    = redirect_pc_i & ~AW'(3);

    assign instr_valid_o = (r_q_count != 2'd0);
    assign instr_o       = r_q_instr[r_q_head];
    assign pc_o          = r_q_pc[r_q_head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_q_count     <= '0;
            r_q_head      <= 1'b0;
            r_if_rd       <= 1'b0;
            r_if_wr       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
                r_if_pc[i]   <= '0;
            end
        end else begin
            case (r_state)
                S_BOOT:  r_state <= S_RUN;
                S_RUN:   if (redirect_i && w_drop_reload != 2'd0) r_state <= S_FLUSH;
                S_FLUSH: if (!redirect_i && w_drop_nxt == 2'd0) r_state <= S_RUN;
                default: r_state <= S_BOOT;
            endcase

            if (redirect_i)    r_pc <= w_redir_pc;
            else if (w_accept) r_pc <= r_pc + AW'(4);

            r_outstanding <= w_out_nxt;
            r_drop_cnt    <= w_drop_nxt;

            // PC of every accepted request, popped by its response whether kept or dropped.
            if (w_accept) begin
                r_if_pc[r_if_wr] <= r_pc;
                r_if_wr          <= ~r_if_wr;
            end
            if (imem_rsp_valid_i) r_if_rd <= ~r_if_rd;

            if (redirect_i) begin
                r_q_count <= '0;
            end else begin
                if (w_push) begin
                    r_q_instr[w_q_tail] <= imem_rsp_data_i;
                    r_q_pc[w_q_tail]    <= r_if_pc[r_if_rd];
                end
                if (w_pop) r_q_head <= ~r_q_head;
                r_q_count <= r_q_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid_i |-> (r_outstanding != 2'd0));

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: an in-order memory model plus a program-order
// reference of the fetch and decode PC streams.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .stall_i          (stall_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .pc_o             (pc_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] mq[$];
    int          mq_cyc[$];
    int          cyc = 0;
    int          delivered = 0;
    logic [31:0] exp_fetch, exp_dec;
    logic        h_vld;
    logic [31:0] h_pc, h_instr;

    task automatic model_reset();
        mq.delete();
        mq_cyc.delete();
        exp_fetch = 32'h0;
        exp_dec   = 32'h0;
        h_vld     = 1'b0;
    endtask

    task automatic idle_inputs();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        stall_i          = 1'b0;
    endtask

    // One clock: drive inputs at negedge, sample just after, update the reference.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc,
                        input int rsp_pct, input int rdy_pct);
        logic acc;
        @(negedge clk);
        stall_i          = st;
        redirect_i       = rd;
        redirect_pc_i    = rpc;
        imem_req_ready_i = ($urandom_range(99) < rdy_pct);
        imem_rsp_valid_i = (mq.size() > 0) && (mq_cyc[0] < cyc) && ($urandom_range(99) < rsp_pct);
        imem_rsp_data_i  = imem_rsp_valid_i ? mem(mq[0]) : $urandom;
        #1;
        if (h_vld) begin
            chk("hold_vld", instr_valid_o, 1);
            chk("hold_pc", pc_o, h_pc);
            chk("hold_instr", instr_o, h_instr);
        end
        h_vld   = instr_valid_o && st && !rd;
        h_pc    = pc_o;
        h_instr = instr_o;
        if (rd) begin
            chk("redir_noreq", imem_req_valid_o, 0);
        end else if (instr_valid_o && !st) begin
            chk("dec_pc", pc_o, exp_dec);
            chk("dec_instr", instr_o, mem(exp_dec));
            exp_dec += 32'd4;
            delivered++;
        end
        if (imem_req_valid_o) chk("fetch_addr", imem_addr_o, exp_fetch);
        acc = imem_req_valid_o && imem_req_ready_i;
        if (acc) begin
            mq.push_back(imem_addr_o);
            mq_cyc.push_back(cyc);
            exp_fetch += 32'd4;
            chk("inflight_le2", 32'(mq.size() <= 2), 1);
        end
        if (imem_rsp_valid_i) begin
            void'(mq.pop_front());
            void'(mq_cyc.pop_front());
        end
        if (rd) begin
            exp_fetch = rpc & ~32'd3;
            exp_dec   = rpc & ~32'd3;
        end
        cyc++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("boot_noreq", imem_req_valid_o, 0);
        chk("boot_novld", instr_valid_o, 0);
    endtask

    initial begin
        int d0;
        int n;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_req_valid", imem_req_valid_o, 0);
        chk("rst_instr_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", pc_o, 0);
        #20;
        release_reset();

        // Streaming with an always-ready, single-cycle memory.
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 32'h0, 100, 100);
        chk("stream_progress", 32'(delivered >= 8), 1);

        // Stall with queue filling; nothing may be lost or duplicated.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h0, 100, 100);
        chk("stall_noreq", imem_req_valid_o, 0);
        chk("stall_full_vld", instr_valid_o, 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0, 100, 100);

        // Redirect with two requests in flight.
        n = 0;
        while (mq.size() < 2 && n < 20) begin
            tick(1'b0, 1'b0, 32'h0, 0, 100);
            n++;
        end
        chk("two_outstanding", mq.size(), 2);
        tick(1'b0, 1'b1, 32'h0000_0103, 0, 100);
        d0 = delivered;
        n = 0;
        while (delivered == d0 && n < 30) begin
            tick(1'b0, 1'b0, 32'h0, 100, 100);
            n++;
        end
        chk("redir_progress", 32'(delivered > d0), 1);

        // Redirect colliding with a response while stalled.
        n = 0;
        while (mq.size() == 0 && n < 20) begin
            tick(1'b0, 1'b0, 32'h0, 0, 100);
            n++;
        end
        chk("have_inflight", 32'(mq.size() > 0), 1);
        tick(1'b1, 1'b1, 32'h0000_0200, 100, 100);
        chk("redir_rsp_seen", imem_rsp_valid_i, 1);
        @(posedge clk);
        #1;
        chk("q_empty_after_redir", instr_valid_o, 0);
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 32'h0, 100, 100);

        // PC wrap.
        tick(1'b0, 1'b1, 32'hFFFF_FFFC, 50, 100);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 32'h0, 100, 100);
        chk("wrap_fetch_pc", exp_fetch[31:16], 16'h0000);

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            tick($urandom_range(99) < 25, $urandom_range(99) < 3, $urandom, 70, 70);
        chk("random_progress", 32'(delivered >= 100), 1);

        // Asynchronous reset between edges.
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0, 100, 100);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_req_valid", imem_req_valid_o, 0);
        chk("mid_rst_instr_valid", instr_valid_o, 0);
        chk("mid_rst_instr", instr_o, 0);
        chk("mid_rst_pc", pc_o, 0);
        idle_inputs();
        model_reset();
        release_reset();
        d0 = delivered;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 32'h0, 100, 100);
        chk("post_rst_progress", 32'(delivered > d0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
